// File: rtl/d_ff_pkg.sv
// Shared limits for the d_ff storage primitive.
`timescale 1ns/1ps
package d_ff_pkg;

    localparam int DFF_MIN_WIDTH = 1;
    localparam int DFF_MAX_WIDTH = 1024;

    function automatic bit dff_width_ok(input int w);
        return (w >= DFF_MIN_WIDTH) && (w <= DFF_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/d_ff.sv
// Positive-edge register with synchronous active-high reset; q comes straight off the flop.
`timescale 1ns/1ps
module d_ff
    import d_ff_pkg::*;
#(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Elaboration-time guard; costs nothing in hardware.
    if (!dff_width_ok(WIDTH)) begin : g_bad_width
        $error("d_ff: WIDTH=%0d outside legal range", WIDTH);
    end

    // A floating or X rst falls through to the load path, so only a clean 1 resets.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VALUE;
        else
            q <= d;
    end

endmodule

// File: tb/tb_d_ff.sv
// Directed timeline checks plus a randomized run against a history-based model.
`timescale 1ns/1ps
module tb_d_ff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // scenarios 1-3: 1-bit, reset held low
    logic rst1, d1, q1;
    d_ff #(.WIDTH(1)) u_b1 (.clk(clk), .rst(rst1), .d(d1), .q(q1));

    // scenario 4: 8-bit with non-zero reset value
    logic       rst8;
    logic [7:0] d8, q8;
    d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_b8 (.clk(clk), .rst(rst8), .d(d8), .q(q8));

    // scenario 5: three-stage chain
    logic       crst, cd;
    logic [2:0] cq;
    d_ff #(.WIDTH(1)) u_c0 (.clk(clk), .rst(crst), .d(cd),    .q(cq[0]));
    d_ff #(.WIDTH(1)) u_c1 (.clk(clk), .rst(crst), .d(cq[0]), .q(cq[1]));
    d_ff #(.WIDTH(1)) u_c2 (.clk(clk), .rst(crst), .d(cq[1]), .q(cq[2]));

    // scenario 6: reset left floating
    logic        rz;
    logic [15:0] dr, qr;
    d_ff #(.WIDTH(16), .RESET_VALUE(16'hFFFF)) u_fl (.clk(clk), .rst(rz), .d(dr), .q(qr));

    logic       e1;
    logic [7:0] e8;
    logic [15:0] er;
    logic       chq[$];

    initial begin
        rz = 1'bz; rst1 = 1'b0; crst = 1'b1; cd = 1'b0; dr = '0;
        d1 = 1'b0; d8 = 8'h3C; rst8 = 1'b0;
        #3  d1 = 1'b1;
        #10 chk("s1_load", q1, 1);                  // t=13
            chk("s4_pre", q8, 8'h3C);
            d1 = 1'b0;
        #10 chk("s2_zero", q1, 0);                  // t=23
            d1 = 1'b1;
        #10 chk("s2_one", q1, 1);                   // t=33
        #4  chk("s3_hold_a", q1, 1);                // t=37
            d1 = 1'b0; rst8 = 1'b1;
            chk("s4_rst_wait", q8, 8'h3C);
        #4  chk("s3_hold_b", q1, 1);                // t=41
            d1 = 1'b1;
        #2  chk("s4_sync", q8, 8'h3C);              // t=43
        #4  chk("s3_edge", q1, 1);                  // t=47
            chk("s4_rst", q8, 8'hA5);
            d1 = 1'b0; d8 = 8'hFF;
        #5  d8 = 8'h00;                             // t=52
        #5  chk("s4_rst_hold", q8, 8'hA5);          // t=57
            chk("s3_zero", q1, 0);
            rst8 = 1'b0; d8 = 8'h5A;
        #10 chk("s4_release", q8, 8'h5A);           // t=67

        e1 = d1; e8 = 8'h5A; er = '0;
        chq = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            chk("r_b1", q1, e1);
            chk("r_b8", q8, e8);
            chk("r_float", qr, er);
            for (int k = 0; k < 3; k++)
                chk($sformatf("chain%0d", k), cq[k], chq[2-k]);

            crst = (i < 2);
            cd   = (i == 4) ? 1'b1 : (i < 20 ? 1'b0 : 1'($urandom_range(1)));
            d1   = 1'($urandom_range(1));
            d8   = 8'($urandom);
            rst8 = ($urandom_range(7) == 0);
            dr   = 16'($urandom);

            e1 = d1;
            e8 = rst8 ? 8'hA5 : d8;
            er = dr;
            if (crst) chq = '{1'b0, 1'b0, 1'b0};
            else begin
                chq.push_back(cd);
                void'(chq.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
